// File: rtl/tone_sequencer.sv
// tone_sequencer: queues keypad presses and plays them one at a time as
// fixed-length notes on the shared PWM generator, each followed by a gap.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting; pops the FIFO head into r_key when one is queued
// LOAD   | computes nfreq from r_key and arms the note timer
// PLAY   | tone enabled while the note timer counts down to 0
// GAP    | tone disabled while the gap timer counts down to 0
module tone_sequencer #(
  parameter int NOTE_CYC   = 12_500_000,
  parameter int GAP_CYC    = 2_500_000,
  parameter int DEPTH_LOG2 = 3,
  parameter int N_BASE     = 1000,
  parameter int N_STEP     = 50
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                opr,
  input  logic [3:0]          posicion,
  input  logic                flush,
  output logic [11:0]         nfreq,
  output logic                tone_en,
  output logic                busy,
  output logic                full,
  output logic                dropped,
  output logic [DEPTH_LOG2:0] count
);

  localparam int DEPTH   = 1 << DEPTH_LOG2;
  localparam int MAX_CYC = (NOTE_CYC > GAP_CYC) ? NOTE_CYC : GAP_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0]      NOTE_LOAD = CNT_W'(NOTE_CYC - 1);
  localparam logic [CNT_W-1:0]      GAP_LOAD  = CNT_W'(GAP_CYC - 1);
  localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PLAY = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_opr_q;
  logic [3:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic [3:0]            r_key;
  logic [CNT_W-1:0]      r_cnt;
  logic [11:0]           r_nfreq;
  logic                  r_dropped;

  logic                  w_press;
  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_cnt_zero;
  logic [11:0]           w_n_calc;

  assign w_press    = opr & ~r_opr_q;
  assign w_full     = (r_count == DEPTH_CNT);
  // A full FIFO rejects the press even if a pop frees a slot this same cycle.
  assign w_push     = w_press & ~w_full & ~flush;
  assign w_pop      = (r_state == S_IDLE) & (r_count != '0) & ~flush;
  assign w_cnt_zero = (r_cnt == '0);
  assign w_n_calc   = 12'(N_BASE) + 12'(N_STEP) * {8'd0, r_key};

  assign nfreq   = r_nfreq;
  assign full    = w_full;
  assign dropped = r_dropped;
  assign count   = r_count;

  // Keypad level history for rising-edge press detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_opr_q <= 1'b0;
    else      r_opr_q <= opr;
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= posicion;
  end

  // FIFO pointers, occupancy and the overflow pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_dropped <= 1'b0;
    end else if (flush) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_dropped <= 1'b0;
    end else begin
      r_dropped <= w_press & w_full;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // FSM next-state logic; flush overrides every transition.
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (r_count != '0) w_state_nxt = S_LOAD;
        S_LOAD:  w_state_nxt = S_PLAY;
        S_PLAY:  if (w_cnt_zero) w_state_nxt = S_GAP;
        S_GAP:   if (w_cnt_zero) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // FSM outputs, decoded from the registered state so reset cuts the tone at once.
  always_comb begin
    tone_en = 1'b0;
    busy    = 1'b0;
    if (r_state == S_PLAY) tone_en = 1'b1;
    if ((r_state != S_IDLE) || (r_count != '0)) busy = 1'b1;
  end

  // Note/gap down-counter, popped key and the N value; nfreq holds outside LOAD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_key   <= '0;
      r_nfreq <= '0;
    end else if (!flush) begin
      if (w_pop) r_key <= r_mem[r_rd_ptr];
      case (r_state)
        S_LOAD: begin
          r_nfreq <= w_n_calc;
          r_cnt   <= NOTE_LOAD;
        end
        S_PLAY:  r_cnt <= w_cnt_zero ? GAP_LOAD : r_cnt - 1'b1;
        S_GAP:   if (!w_cnt_zero) r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer: directed table and sequences plus randomized
// traffic checked each cycle against a timeline-based reference model.
module tb_tone_sequencer;

  localparam int NOTE  = 8;
  localparam int GAP   = 4;
  localparam int DL2   = 2;
  localparam int DEPTH = 4;
  localparam int NB    = 1000;
  localparam int NS    = 50;

  logic         clk = 1'b0;
  logic         rst;
  logic         opr;
  logic [3:0]   posicion;
  logic         flush;
  logic [11:0]  nfreq;
  logic         tone_en;
  logic         busy;
  logic         full;
  logic         dropped;
  logic [DL2:0] count;

  tone_sequencer #(
    .NOTE_CYC(NOTE), .GAP_CYC(GAP), .DEPTH_LOG2(DL2), .N_BASE(NB), .N_STEP(NS)
  ) dut (
    .clk(clk), .rst(rst), .opr(opr), .posicion(posicion), .flush(flush),
    .nfreq(nfreq), .tone_en(tone_en), .busy(busy), .full(full),
    .dropped(dropped), .count(count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Reference model: a queue of keys plus the phase of the current note,
  // counted in cycles since the pop (0 = load, 1..NOTE = tone, then gap).
  int m_q[$];
  bit m_opr_q = 1'b0;
  int m_phase = -1;
  int m_key = 0;
  int m_nfreq = 0;
  bit m_drop = 1'b0;
  bit m_pr, m_was_full;

  always @(posedge clk) begin
    if (!rst) begin
      m_q.delete();
      m_opr_q = 1'b0;
      m_phase = -1;
      m_nfreq = 0;
      m_drop  = 1'b0;
    end else begin
      m_pr    = opr && !m_opr_q;
      m_opr_q = opr;
      if (flush) begin
        m_q.delete();
        m_phase = -1;
        m_drop  = 1'b0;
      end else begin
        m_was_full = (m_q.size() == DEPTH);
        if (m_phase >= 0) begin
          m_phase++;
          if (m_phase == 1) m_nfreq = (NB + NS * m_key) % 4096;
          if (m_phase > NOTE + GAP) m_phase = -1;
        end else if (m_q.size() > 0) begin
          m_key   = m_q.pop_front();
          m_phase = 0;
        end
        if (m_pr && !m_was_full) m_q.push_back(int'(posicion));
        m_drop = m_pr && m_was_full;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    check("m_tone_en", tone_en, (m_phase >= 1 && m_phase <= NOTE));
    check("m_busy", busy, (m_phase != -1 || m_q.size() > 0));
    check("m_count", count, m_q.size());
    check("m_full", full, (m_q.size() == DEPTH));
    check("m_dropped", dropped, m_drop);
    check("m_nfreq", nfreq, m_nfreq);
  end

  // Tone-start log: N value and cycle of every rising edge of tone_en.
  int   t_n[$];
  int   t_cyc[$];
  logic prev_tone = 1'b0;
  always @(negedge clk) begin
    if (tone_en && !prev_tone) begin
      t_n.push_back(int'(nfreq));
      t_cyc.push_back(cyc);
    end
    prev_tone = tone_en;
  end

  task automatic wait_idle();
    int n = 0;
    while ((busy || tone_en) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_idle: still busy after %0d cycles", n);
    end
    @(negedge clk);
  endtask

  task automatic press_pulse(input int key);
    opr = 1'b1;
    posicion = 4'(key);
    @(negedge clk);
    opr = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    int key;
    int exp_n;
  } vec_t;
  vec_t vec[6];

  int hi, lo;

  initial begin
    vec[0] = '{5, 1250};
    vec[1] = '{0, 1000};
    vec[2] = '{15, 1750};
    vec[3] = '{7, 1350};
    vec[4] = '{1, 1050};
    vec[5] = '{10, 1500};

    rst = 1'b0; opr = 1'b0; posicion = 4'd0; flush = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tone", tone_en, 0);
    check("rst_nfreq", nfreq, 0);
    check("rst_busy", busy, 0);
    check("rst_count", count, 0);
    check("rst_full", full, 0);
    check("rst_dropped", dropped, 0);
    rst = 1'b1;
    @(negedge clk);

    // Single presses: latency, N value, note and gap lengths.
    for (int i = 0; i < 6; i++) begin
      wait_idle();
      opr = 1'b1;
      posicion = 4'(vec[i].key);
      @(negedge clk);
      check("single_count", count, 1);
      check("single_tone_k", tone_en, 0);
      @(negedge clk);
      check("single_tone_k1", tone_en, 0);
      @(negedge clk);
      opr = 1'b0;
      check("single_tone_k2", tone_en, 1);
      check("single_nfreq", nfreq, vec[i].exp_n);
      hi = 0;
      while (tone_en && hi < 40) begin hi++; @(negedge clk); end
      check("single_note_len", hi, NOTE);
      lo = 0;
      while (!tone_en && busy && lo < 40) begin lo++; @(negedge clk); end
      check("single_gap_len", lo, GAP);
      check("single_busy_end", busy, 0);
    end

    // Queue order and back-to-back spacing.
    wait_idle();
    t_n.delete(); t_cyc.delete();
    press_pulse(0); press_pulse(15); press_pulse(7);
    wait_idle();
    check("order_notes", t_n.size(), 3);
    if (t_n.size() == 3) begin
      check("order_n0", t_n[0], 1000);
      check("order_n1", t_n[1], 1750);
      check("order_n2", t_n[2], 1350);
      check("order_gap01", t_cyc[1] - t_cyc[0], NOTE + GAP + 2);
      check("order_gap12", t_cyc[2] - t_cyc[1], NOTE + GAP + 2);
    end

    // Overflow: one playing, four queued, sixth press dropped.
    t_n.delete(); t_cyc.delete();
    press_pulse(1); press_pulse(2); press_pulse(3); press_pulse(4); press_pulse(6);
    check("ovf_count_full", count, 4);
    check("ovf_full", full, 1);
    check("ovf_no_drop_yet", dropped, 0);
    opr = 1'b1; posicion = 4'd9;
    @(negedge clk);
    opr = 1'b0;
    check("ovf_dropped", dropped, 1);
    check("ovf_count_held", count, 4);
    @(negedge clk);
    check("ovf_dropped_1cyc", dropped, 0);
    wait_idle();
    check("ovf_notes", t_n.size(), 5);
    if (t_n.size() == 5) begin
      check("ovf_n0", t_n[0], 1050);
      check("ovf_n1", t_n[1], 1100);
      check("ovf_n2", t_n[2], 1150);
      check("ovf_n3", t_n[3], 1200);
      check("ovf_n4", t_n[4], 1300);
    end

    // Push coinciding with the IDLE pop.
    t_n.delete(); t_cyc.delete();
    press_pulse(2); press_pulse(11);
    repeat (11) @(negedge clk);
    check("pp_idle_tone", tone_en, 0);
    check("pp_idle_count", count, 1);
    opr = 1'b1; posicion = 4'd13;
    @(negedge clk);
    opr = 1'b0;
    check("pp_count_same", count, 1);
    check("pp_load_tone", tone_en, 0);
    wait_idle();
    check("pp_notes", t_n.size(), 3);
    if (t_n.size() == 3) begin
      check("pp_n0", t_n[0], 1100);
      check("pp_n1", t_n[1], 1550);
      check("pp_n2", t_n[2], 1650);
    end

    // Flush during PLAY with three queued entries and a same-cycle press.
    t_n.delete(); t_cyc.delete();
    press_pulse(6); press_pulse(8); press_pulse(9); press_pulse(12);
    check("fl_pre_tone", tone_en, 1);
    check("fl_pre_count", count, 3);
    flush = 1'b1; opr = 1'b1; posicion = 4'd14;
    @(negedge clk);
    flush = 1'b0; opr = 1'b0;
    check("fl_tone", tone_en, 0);
    check("fl_count", count, 0);
    check("fl_busy", busy, 0);
    check("fl_dropped", dropped, 0);
    check("fl_nfreq_kept", nfreq, 1300);
    repeat (3) @(negedge clk);
    check("fl_stay_idle", busy, 0);
    check("fl_notes", t_n.size(), 1);

    // Reset asserted mid-PLAY.
    wait_idle();
    press_pulse(3);
    repeat (3) @(negedge clk);
    check("rp_tone_on", tone_en, 1);
    check("rp_nfreq_on", nfreq, 1150);
    #2 rst = 1'b0;
    #1;
    check("rp_tone_cut", tone_en, 0);
    check("rp_nfreq_zero", nfreq, 0);
    check("rp_count", count, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rp_busy_after", busy, 0);
    check("rp_count_after", count, 0);

    // Randomized traffic, checked by the reference model each cycle.
    for (int i = 0; i < 3000; i++) begin
      opr      = ($urandom_range(0, 99) < 40);
      posicion = 4'($urandom_range(0, 15));
      flush    = ($urandom_range(0, 249) == 0);
      @(negedge clk);
    end
    opr = 1'b0; flush = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
